dm_stage: RTL and testbench
===========================

DM_STAGE -- requirements
Module: dm_stage

Interface
REQ-001 SHALL provide: DM_BASE, 32'h0000_0000, byte address of first data-memory word.
REQ-002 SHALL provide: DM_WORDS, 3072, number of 32-bit words (address range DM_BASE .. DM_BASE+4*DM_WORDS-1 = 0x0000_2FFF).
REQ-003 SHALL provide: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL provide: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide: opcodeM  input  6  M-stage instruction opcode.
REQ-006 SHALL provide: addrM  input  32  M-stage effective byte address.
REQ-007 SHALL provide: wdataM  input  32  M-stage store data, forwarded, right-aligned.
REQ-008 SHALL provide: flushM  input  1  kill M-stage instruction: exception or interrupt taken this cycle.
REQ-009 SHALL provide: excM  output  1  M-stage address exception, combinational.
REQ-010 SHALL provide: excCodeM  output  5  4 = AdEL, 5 = AdES, 0 otherwise.
REQ-011 SHALL provide: DMoutW  output  32  raw memory word for W-stage load extender.
REQ-012 SHALL provide: addrW  output  2  addrM[1:0] registered into W.
REQ-013 SHALL provide: opcodeW  output  6  opcodeM registered into W.

Function
REQ-014 SHALL decode loads lw=35, lb=32, lbu=36, lh=33, lhu=37 and stores sw=43, sb=40, sh=41; all other opcodes are non-memory.
REQ-015 SHALL flag misalignment: lw/sw with addrM[1:0]!=0; lh/lhu/sh with addrM[0]!=0; byte ops never misaligned.
REQ-016 SHALL flag out-of-range: any load/store with addrM outside DM_BASE .. DM_BASE+4*DM_WORDS-1.
REQ-017 SHALL drive excM=1 on misalignment or out-of-range: excCodeM=4 for loads, 5 for stores; excM=0 and excCodeM=0 for non-memory opcodes.
REQ-018 SHALL index the array by word = (addrM-DM_BASE)[13:2].
REQ-019 SHALL generate byte enables: sw -> 4'b1111; sh -> 4'b0011 at addr[1]=0, 4'b1100 at addr[1]=1; sb -> one-hot bit addr[1:0].
REQ-020 SHALL place store data: sh -> wdataM[15:0] replicated to both halves; sb -> wdataM[7:0] replicated to all four bytes; only enabled bytes written.
REQ-021 SHALL commit a store at the rising edge ending its M cycle, only when store && !excM && !flushM && !reset.
REQ-022 SHALL leave memory unchanged for suppressed stores; no partial write on exception.
REQ-023 SHALL read the addressed word combinationally in M and register it into DMoutW at the same edge, latency 1 cycle.
REQ-024 SHALL, for a load in the cycle immediately after a store to the same word, return the post-store word.
REQ-025 SHALL register addrW and opcodeW at every edge.
REQ-026 SHALL, when flushM=1 or excM=1, load opcodeW=0, addrW=0, DMoutW=0 so W sees a nop.
REQ-027 SHALL, for non-load opcodes, capture DMoutW as the array word when in range, else 0.
REQ-028 SHALL not stall: one instruction accepted per cycle, no backpressure.

Reset
REQ-029 SHALL, on reset=1 at a rising edge, clear DMoutW, addrW and opcodeW to 0.
REQ-030 SHALL, on reset=1 at a rising edge, clear every memory word to 0.
REQ-031 SHALL suppress any store presented in the reset cycle.
REQ-032 SHALL keep excM/excCodeM combinational and unaffected by reset.

Verification
REQ-033 SHALL cover: sw 0x12345678 @0x10, next cycle lw @0x10 -> DMoutW=0x12345678 one cycle later, opcodeW=35, addrW=0.
REQ-034 SHALL cover: sb 0xAB @0x13 over 0x12345678 -> word 0xAB345678; sh 0xBEEF @0x12 -> 0xBEEF5678.
REQ-035 SHALL cover: lh @0x11 -> excM=1, excCodeM=4, opcodeW=0 next edge; sw @0x3000 -> excM=1, excCodeM=5, memory unchanged.
REQ-036 SHALL cover: sw 0xFFFFFFFF @0x20 with flushM=1 -> word 0x20 unchanged, opcodeW=0.
REQ-037 SHALL cover: reset asserted during sw 0x1 @0x0 -> word 0x0 reads 0, all W outputs 0.
REQ-038 SHALL cover: back-to-back sw @0x0, sw @0x0, lw @0x0 with data 0x1 then 0x2 -> DMoutW=0x2.

Source files
------------

// File: rtl/dm_stage_if.sv
// M-stage request and W-stage result bundle for the data-memory stage.
interface dm_stage_if;
    logic [5:0]  opcodeM;
    logic [31:0] addrM;
    logic [31:0] wdataM;
    logic        flushM;
    logic        excM;
    logic [4:0]  excCodeM;
    logic [31:0] DMoutW;
    logic [1:0]  addrW;
    logic [5:0]  opcodeW;

    modport master (
        output opcodeM, addrM, wdataM, flushM,
        input  excM, excCodeM, DMoutW, addrW, opcodeW
    );

    modport slave (
        input  opcodeM, addrM, wdataM, flushM,
        output excM, excCodeM, DMoutW, addrW, opcodeW
    );
endinterface

// File: rtl/dm_stage.sv
// Data-memory pipeline stage: address checking and byte-lane stores in M,
// word read registered into W for the downstream load extender.
module dm_stage #(
    parameter logic [31:0] DM_BASE  = 32'h0000_0000,
    parameter int          DM_WORDS = 3072
) (
    input  logic     clk,
    input  logic     reset,
    dm_stage_if.slave d
);
    localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

    localparam logic [5:0] OP_LB  = 6'd32;
    localparam logic [5:0] OP_LH  = 6'd33;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_LBU = 6'd36;
    localparam logic [5:0] OP_LHU = 6'd37;
    localparam logic [5:0] OP_SB  = 6'd40;
    localparam logic [5:0] OP_SH  = 6'd41;
    localparam logic [5:0] OP_SW  = 6'd43;

    logic [31:0] mem [DM_WORDS];

    logic [31:0] off_m;
    logic        in_range_m;
    logic [11:0] word_m;
    logic        is_load_m;
    logic        is_store_m;
    logic        misalign_m;
    logic        exc_m;
    logic [4:0]  exc_code_m;
    logic        we_m;
    logic [3:0]  be_m;
    logic [31:0] wdata_m;
    logic [31:0] rd_word_m;

    logic [31:0] dmout_p1;
    logic [1:0]  addr_p1;
    logic [5:0]  opcode_p1;

    function automatic logic [3:0] byte_enable(input logic [5:0] op, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (op)
            OP_SW:   be = 4'b1111;
            OP_SH:   be = a[1] ? 4'b1100 : 4'b0011;
            OP_SB:   be = 4'b0001 << a;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Sub-word stores replicate their data across lanes; the enables pick the lane.
    function automatic logic [31:0] store_lanes(input logic [5:0] op, input logic [31:0] wd);
        logic [31:0] v;
        case (op)
            OP_SH:   v = {2{wd[15:0]}};
            OP_SB:   v = {4{wd[7:0]}};
            default: v = wd;
        endcase
        return v;
    endfunction

    // ---- M stage: decode, address check, combinational read ----
    // Subtracting the base first makes addresses below DM_BASE wrap high and fail the bound.
    assign off_m      = d.addrM - DM_BASE;
    assign in_range_m = (off_m < DM_BYTES);
    assign word_m     = off_m[13:2];

    always_comb begin
        is_load_m  = 1'b0;
        is_store_m = 1'b0;
        misalign_m = 1'b0;
        case (d.opcodeM)
            OP_LW:         begin is_load_m  = 1'b1; misalign_m = (d.addrM[1:0] != 2'b00); end
            OP_LH, OP_LHU: begin is_load_m  = 1'b1; misalign_m = d.addrM[0]; end
            OP_LB, OP_LBU: begin is_load_m  = 1'b1; end
            OP_SW:         begin is_store_m = 1'b1; misalign_m = (d.addrM[1:0] != 2'b00); end
            OP_SH:         begin is_store_m = 1'b1; misalign_m = d.addrM[0]; end
            OP_SB:         begin is_store_m = 1'b1; end
            default:       begin end
        endcase
        exc_m      = (is_load_m || is_store_m) && (misalign_m || !in_range_m);
        exc_code_m = 5'd0;
        if (exc_m) exc_code_m = is_load_m ? 5'd4 : 5'd5;
    end

    assign d.excM     = exc_m;
    assign d.excCodeM = exc_code_m;

    assign we_m      = is_store_m && !exc_m && !d.flushM;
    assign be_m      = byte_enable(d.opcodeM, d.addrM[1:0]);
    assign wdata_m   = store_lanes(d.opcodeM, d.wdataM);
    assign rd_word_m = in_range_m ? mem[word_m] : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) mem[i] <= 32'h0;
        end else if (we_m) begin
            for (int b = 0; b < 4; b++)
                if (be_m[b]) mem[word_m][8*b +: 8] <= wdata_m[8*b +: 8];
        end
    end

    // ---- M/W boundary: killed or faulting instructions become a nop ----
    always_ff @(posedge clk) begin
        if (reset || d.flushM || exc_m) begin
            dmout_p1  <= 32'h0;
            addr_p1   <= 2'b00;
            opcode_p1 <= 6'd0;
        end else begin
            dmout_p1  <= rd_word_m;
            addr_p1   <= d.addrM[1:0];
            opcode_p1 <= d.opcodeM;
        end
    end

    assign d.DMoutW  = dmout_p1;
    assign d.addrW   = addr_p1;
    assign d.opcodeW = opcode_p1;
endmodule

// File: tb/tb_dm_stage.sv
// Directed bench for dm_stage: stores, loads, address exceptions, flush and reset.
module tb_dm_stage;
    localparam logic [5:0] NOP = 6'd0,  LB = 6'd32, LH = 6'd33, LW = 6'd35, LBU = 6'd36;
    localparam logic [5:0] SB  = 6'd40, SH = 6'd41, SW = 6'd43, ADDI = 6'd8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    dm_stage_if bus ();

    dm_stage dut (
        .clk   (clk),
        .reset (reset),
        .d     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Present one instruction at the falling edge; after it returns, the M-stage
    // outputs belong to this instruction and the W outputs to the previous one.
    task automatic drive(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic fl, input logic rst);
        @(negedge clk);
        reset       = rst;
        bus.opcodeM = op;
        bus.addrM   = addr;
        bus.wdataM  = wd;
        bus.flushM  = fl;
        #1;
    endtask

    task automatic rdword(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        drive(LW, addr, 32'h0, 1'b0, 1'b0);
        drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        check(tag, bus.DMoutW, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.opcodeM = NOP; bus.addrM = 32'h0; bus.wdataM = 32'h0; bus.flushM = 1'b0;

        drive(SW, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        drive(LH, 32'h11, 32'h0, 1'b0, 1'b1);
        check("reset_dmout", bus.DMoutW, 32'h0);
        check("reset_opW", {26'h0, bus.opcodeW}, 32'h0);
        check("reset_addrW", {30'h0, bus.addrW}, 32'h0);
        check("exc_in_reset", {31'h0, bus.excM}, 32'h1);
        check("exccode_in_reset", {27'h0, bus.excCodeM}, 32'd4);
        drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);

        // store then immediately load the same word
        drive(SW, 32'h10, 32'h1234_5678, 1'b0, 1'b0);
        check("sw_noexc", {31'h0, bus.excM}, 32'h0);
        drive(LW, 32'h10, 32'h0, 1'b0, 1'b0);
        check("lw_noexc", {31'h0, bus.excM}, 32'h0);
        drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        check("lw_fwd_data", bus.DMoutW, 32'h1234_5678);
        check("lw_opW", {26'h0, bus.opcodeW}, 32'd35);
        check("lw_addrW", {30'h0, bus.addrW}, 32'h0);

        // sub-word stores into word 0x10
        drive(SB, 32'h13, 32'h0000_00AB, 1'b0, 1'b0);
        rdword("sb_lane3", 32'h10, 32'hAB34_5678);
        drive(SH, 32'h12, 32'h0000_BEEF, 1'b0, 1'b0);
        rdword("sh_upper", 32'h10, 32'hBEEF_5678);
        drive(SH, 32'h10, 32'hFFFF_1234, 1'b0, 1'b0);
        rdword("sh_lower", 32'h10, 32'hBEEF_1234);
        drive(SB, 32'h11, 32'h1111_11CD, 1'b0, 1'b0);
        rdword("sb_lane1", 32'h10, 32'hBEEF_CD34);
        drive(LBU, 32'h13, 32'h0, 1'b0, 1'b0);
        drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        check("lbu_addrW", {30'h0, bus.addrW}, 32'd3);
        check("lbu_opW", {26'h0, bus.opcodeW}, 32'd36);
        check("lbu_data", bus.DMoutW, 32'hBEEF_CD34);

        // misaligned load becomes a nop in W
        drive(LH, 32'h11, 32'h0, 1'b0, 1'b0);
        check("lh_mis_exc", {31'h0, bus.excM}, 32'h1);
        check("lh_mis_code", {27'h0, bus.excCodeM}, 32'd4);
        drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        check("lh_mis_opW", {26'h0, bus.opcodeW}, 32'h0);
        check("lh_mis_dmout", bus.DMoutW, 32'h0);

        // misaligned store leaves the word alone
        drive(SW, 32'h12, 32'h5555_5555, 1'b0, 1'b0);
        check("sw_mis_code", {27'h0, bus.excCodeM}, 32'd5);
        rdword("sw_mis_nowrite", 32'h10, 32'hBEEF_CD34);

        // top-of-memory boundary
        drive(SW, 32'h2FFC, 32'hCAFE_F00D, 1'b0, 1'b0);
        check("sw_last_noexc", {31'h0, bus.excM}, 32'h0);
        drive(SW, 32'h3000, 32'h7777_7777, 1'b0, 1'b0);
        check("sw_oor_exc", {31'h0, bus.excM}, 32'h1);
        check("sw_oor_code", {27'h0, bus.excCodeM}, 32'd5);
        rdword("sw_oor_last", 32'h2FFC, 32'hCAFE_F00D);
        rdword("sw_oor_first", 32'h0, 32'h0);
        drive(LB, 32'h2FFF, 32'h0, 1'b0, 1'b0);
        check("lb_top_noexc", {31'h0, bus.excM}, 32'h0);
        drive(LW, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        check("lw_wrap_code", {27'h0, bus.excCodeM}, 32'd4);
        drive(LB, 32'h3000, 32'h0, 1'b0, 1'b0);
        check("lb_oor_code", {27'h0, bus.excCodeM}, 32'd4);

        // non-memory opcodes never fault and carry the array word when in range
        drive(ADDI, 32'h3001, 32'h0, 1'b0, 1'b0);
        check("addi_noexc", {31'h0, bus.excM}, 32'h0);
        check("addi_code", {27'h0, bus.excCodeM}, 32'h0);
        drive(ADDI, 32'h12, 32'h0, 1'b0, 1'b0);
        check("addi_oor_dmout", bus.DMoutW, 32'h0);
        check("addi_oor_addrW", {30'h0, bus.addrW}, 32'd1);
        check("addi_opW", {26'h0, bus.opcodeW}, 32'd8);
        drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        check("addi_in_dmout", bus.DMoutW, 32'hBEEF_CD34);
        check("addi_in_addrW", {30'h0, bus.addrW}, 32'd2);

        // flushed store and flushed load
        drive(SW, 32'h20, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        check("flush_opW", {26'h0, bus.opcodeW}, 32'h0);
        rdword("flush_nowrite", 32'h20, 32'h0);
        drive(LW, 32'h10, 32'h0, 1'b1, 1'b0);
        drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        check("flush_lw_dmout", bus.DMoutW, 32'h0);

        // reset during a store clears memory and W
        drive(SW, 32'h0, 32'h0000_0005, 1'b0, 1'b0);
        rdword("pre_reset_word", 32'h0, 32'h5);
        drive(LW, 32'h10, 32'h0, 1'b0, 1'b0);
        drive(SW, 32'h0, 32'h0000_0001, 1'b0, 1'b1);
        drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        check("rst_dmout", bus.DMoutW, 32'h0);
        check("rst_opW", {26'h0, bus.opcodeW}, 32'h0);
        rdword("rst_word0", 32'h0, 32'h0);
        rdword("rst_word10", 32'h10, 32'h0);
        rdword("rst_word_last", 32'h2FFC, 32'h0);

        // back-to-back stores to one word then a load
        drive(SW, 32'h0, 32'h1, 1'b0, 1'b0);
        drive(SW, 32'h0, 32'h2, 1'b0, 1'b0);
        drive(LW, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        check("b2b_dmout", bus.DMoutW, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
